// File: rtl/gb_cpu_pkg.sv
// Shared CPU definitions: register indices, data-in source selects,
// opcode constants, sequencer state encoding and the opcode classifier.
package gb_cpu_pkg;

    // Register select encoding used by the register file
    localparam logic [2:0] REG_B      = 3'd0;
    localparam logic [2:0] REG_C      = 3'd1;
    localparam logic [2:0] REG_D      = 3'd2;
    localparam logic [2:0] REG_E      = 3'd3;
    localparam logic [2:0] REG_H      = 3'd4;
    localparam logic [2:0] REG_L      = 3'd5;
    localparam logic [2:0] REG_HL_IND = 3'd6;
    localparam logic [2:0] REG_A      = 3'd7;

    // Register file data-in mux legs
    localparam logic [1:0] SRC_LOOP = 2'b00;
    localparam logic [1:0] SRC_TB   = 2'b11;

    // Opcodes with a dedicated meaning
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_HALT = 8'h76;

    // T-counter width, wide enough for up to 8 clocks per machine cycle
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR       = 3'd2,
        ST_WAIT_IMM = 3'd3,
        ST_IMM_WR   = 3'd4,
        ST_HALT     = 3'd5
    } seq_state_e;

    typedef enum logic [2:0] {
        OPC_NOP   = 3'd0,
        OPC_LD_RR = 3'd1,
        OPC_LD_RI = 3'd2,
        OPC_HALT  = 3'd3,
        OPC_UNSUP = 3'd4
    } op_class_e;

    // Classify an opcode; any (HL) form falls into OPC_UNSUP.
    // HALT (8'h76) is tested before the LD r,r' pattern it overlaps.
    function automatic op_class_e decode_op(input logic [7:0] opc);
        op_class_e cls_s;
        if (opc == OP_NOP) begin
            cls_s = OPC_NOP;
        end else if (opc == OP_HALT) begin
            cls_s = OPC_HALT;
        end else if ((opc[7:6] == 2'b01) && (opc[5:3] != REG_HL_IND) &&
                     (opc[2:0] != REG_HL_IND)) begin
            cls_s = OPC_LD_RR;
        end else if ((opc[7:6] == 2'b00) && (opc[2:0] == REG_HL_IND) &&
                     (opc[5:3] != REG_HL_IND)) begin
            cls_s = OPC_LD_RI;
        end else begin
            cls_s = OPC_UNSUP;
        end
        return cls_s;
    endfunction

endpackage

// File: rtl/mcycle_counter.sv
// T-state counter for one machine cycle: counts 0..T_PER_M-1 while enabled,
// wraps after the last T, and clears whenever the owner changes state.
module mcycle_counter #(
    parameter int unsigned T_PER_M = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_T = CNT_W'(T_PER_M - 1);

    logic [CNT_W-1:0] count_r;

    // T-state count register with clear and wrap on the last T
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (count_r == LAST_T) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign last = en & (count_r == LAST_T);

endmodule

// File: rtl/reg_op_sequencer.sv
// Register-transfer sequencer: accepts NOP, LD r,r', LD r,d8 and HALT from
// fetch and steps the register file through read/write machine cycles.
// Enables depend only on state and T-counter, never directly on op.
module reg_op_sequencer
    import gb_cpu_pkg::*;
#(
    parameter int unsigned T_PER_M = 4,
    parameter int unsigned SEL_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [7:0]       op,
    output logic             op_ready,
    input  logic             imm_valid,
    input  logic [7:0]       imm_data,
    output logic             imm_ready,
    output logic [7:0]       imm_out,
    input  logic             wake,
    output logic             reg_rd_en,
    output logic [SEL_W-1:0] reg_rd_sel,
    output logic             reg_wr_en,
    output logic [SEL_W-1:0] reg_wr_sel,
    output logic [1:0]       reg_src_sel,
    output logic             busy,
    output logic             halted,
    output logic             op_unsupported
);

    seq_state_e       state_r;
    seq_state_e       state_next_s;
    op_class_e        op_class_s;
    logic             accept_s;
    logic             imm_take_s;
    logic             cnt_en_s;
    logic             cnt_clr_s;
    logic             last_t_s;
    logic [SEL_W-1:0] rd_sel_r;
    logic [SEL_W-1:0] wr_sel_r;
    logic [SEL_W-1:0] dst_r;
    logic [1:0]       src_sel_r;
    logic [7:0]       imm_out_r;
    logic             op_unsup_r;

    assign op_class_s = decode_op(op);
    assign accept_s   = (state_r == ST_IDLE) & op_valid;
    assign imm_take_s = (state_r == ST_WAIT_IMM) & imm_valid;
    assign cnt_en_s   = (state_r == ST_RD) | (state_r == ST_WR) | (state_r == ST_IMM_WR);
    assign cnt_clr_s  = (state_next_s != state_r);

    mcycle_counter #(
        .T_PER_M (T_PER_M),
        .CNT_W   (CNT_W)
    ) u_tcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr_s),
        .en   (cnt_en_s),
        .last (last_t_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op_class_s)
                        OPC_LD_RR: state_next_s = ST_RD;
                        OPC_LD_RI: state_next_s = ST_WAIT_IMM;
                        OPC_HALT:  state_next_s = ST_HALT;
                        default:   state_next_s = ST_IDLE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (last_t_s) begin
                    state_next_s = ST_WR;
                end else begin
                    state_next_s = ST_RD;
                end
            end
            ST_WR, ST_IMM_WR: begin
                if (last_t_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_WAIT_IMM: begin
                if (imm_valid) begin
                    state_next_s = ST_IMM_WR;
                end else begin
                    state_next_s = ST_WAIT_IMM;
                end
            end
            ST_HALT: begin
                if (wake) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake, status and enable outputs from state and T-counter
    always_comb begin
        op_ready  = 1'b0;
        imm_ready = 1'b0;
        reg_rd_en = 1'b0;
        reg_wr_en = 1'b0;
        busy      = 1'b1;
        halted    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                op_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_RD:       reg_rd_en = last_t_s;
            ST_WR:       reg_wr_en = last_t_s;
            ST_WAIT_IMM: imm_ready = imm_valid;
            ST_IMM_WR:   reg_wr_en = last_t_s;
            ST_HALT:     halted    = 1'b1;
            default: begin
                op_ready = 1'b0;
                busy     = 1'b1;
            end
        endcase
    end

    // Operand, select, immediate and unsupported-pulse registers; selects
    // are loaded on entry to the state that uses them and then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel_r   <= {SEL_W{1'b0}};
            wr_sel_r   <= {SEL_W{1'b0}};
            dst_r      <= {SEL_W{1'b0}};
            src_sel_r  <= SRC_LOOP;
            imm_out_r  <= 8'h00;
            op_unsup_r <= 1'b0;
        end else begin
            op_unsup_r <= accept_s & (op_class_s == OPC_UNSUP);
            if (accept_s && (op_class_s == OPC_LD_RR)) begin
                rd_sel_r <= SEL_W'(op[2:0]);
                dst_r    <= SEL_W'(op[5:3]);
            end
            if (accept_s && (op_class_s == OPC_LD_RI)) begin
                dst_r <= SEL_W'(op[5:3]);
            end
            if ((state_r == ST_RD) && last_t_s) begin
                wr_sel_r  <= dst_r;
                src_sel_r <= SRC_LOOP;
            end
            if (imm_take_s) begin
                imm_out_r <= imm_data;
                wr_sel_r  <= dst_r;
                src_sel_r <= SRC_TB;
            end
        end
    end

    assign reg_rd_sel     = rd_sel_r;
    assign reg_wr_sel     = wr_sel_r;
    assign reg_src_sel    = src_sel_r;
    assign imm_out        = imm_out_r;
    assign op_unsupported = op_unsup_r;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer with T_PER_M = 4.
module tb_reg_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [7:0] op;
    logic       op_ready;
    logic       imm_valid;
    logic [7:0] imm_data;
    logic       imm_ready;
    logic [7:0] imm_out;
    logic       wake;
    logic       rd_en;
    logic [2:0] rd_sel;
    logic       wr_en;
    logic [2:0] wr_sel;
    logic [1:0] src_sel;
    logic       busy;
    logic       halted;
    logic       op_unsup;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_op_sequencer #(.T_PER_M(4), .SEL_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .op_valid       (op_valid),
        .op             (op),
        .op_ready       (op_ready),
        .imm_valid      (imm_valid),
        .imm_data       (imm_data),
        .imm_ready      (imm_ready),
        .imm_out        (imm_out),
        .wake           (wake),
        .reg_rd_en      (rd_en),
        .reg_rd_sel     (rd_sel),
        .reg_wr_en      (wr_en),
        .reg_wr_sel     (wr_sel),
        .reg_src_sel    (src_sel),
        .busy           (busy),
        .halted         (halted),
        .op_unsupported (op_unsup)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_op_ready"}, op_ready, 1);
        check({tag, "_imm_ready"}, imm_ready, 0);
        check({tag, "_imm_out"}, imm_out, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_sel"}, rd_sel, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_sel"}, wr_sel, 0);
        check({tag, "_src_sel"}, src_sel, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_unsup"}, op_unsup, 0);
    endtask

    // Accept an LD r,r' in cycle 0; read on cycle 4, write on cycle 8, ready on 9
    task automatic ld_rr_run(input logic [7:0] opc, input logic [2:0] es, input logic [2:0] ed);
        op = opc;
        op_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("ldrr_rd_en", rd_en, (c == 4));
            check("ldrr_wr_en", wr_en, (c == 8));
            check("ldrr_op_ready", op_ready, (c == 0) || (c == 9));
            check("ldrr_busy", busy, (c >= 1) && (c <= 8));
            if (c == 4) check("ldrr_rd_sel", rd_sel, es);
            if (c == 8) begin
                check("ldrr_wr_sel", wr_sel, ed);
                check("ldrr_src_sel", src_sel, 2'b00);
            end
            tick;
            if (c == 0) op_valid = 1'b0;
        end
    endtask

    logic [7:0] unsup_ops [2] = '{8'h7E, 8'h36};

    initial begin
        rst = 1'b1;
        op_valid = 1'b0;
        op = 8'h00;
        imm_valid = 1'b0;
        imm_data = 8'h00;
        wake = 1'b0;

        // Reset held for two clocks
        repeat (2) tick;
        #1;
        reset_vals("rst");
        rst = 1'b0;
        tick;

        // NOP: single accept clock, no enables, no unsupported pulse
        op = 8'h00;
        op_valid = 1'b1;
        #1;
        check("nop_op_ready", op_ready, 1);
        tick;
        op_valid = 1'b0;
        #1;
        check("nop_busy", busy, 0);
        check("nop_op_ready_after", op_ready, 1);
        check("nop_rd_en", rd_en, 0);
        check("nop_wr_en", wr_en, 0);
        check("nop_unsup", op_unsup, 0);

        // LD B,A straight after the NOP
        ld_rr_run(8'h47, 3'd7, 3'd0);

        // Early immediate while idle is not consumed
        imm_valid = 1'b1;
        imm_data = 8'h3C;
        #1;
        check("early_imm_ready", imm_ready, 0);
        tick;
        imm_valid = 1'b0;
        #1;
        check("early_imm_out", imm_out, 8'h00);

        // LD C,d8 with the immediate arriving after 5 idle clocks
        op = 8'h0E;
        op_valid = 1'b1;
        #1;
        check("ldi_op_ready", op_ready, 1);
        tick;
        op_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("ldi_wait_imm_ready", imm_ready, 0);
            check("ldi_wait_busy", busy, 1);
            check("ldi_wait_op_ready", op_ready, 0);
            check("ldi_wait_wr_en", wr_en, 0);
            tick;
        end
        imm_valid = 1'b1;
        imm_data = 8'hA5;
        #1;
        check("ldi_imm_ready", imm_ready, 1);
        tick;
        imm_valid = 1'b0;
        imm_data = 8'hFF;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("ldi_wr_en", wr_en, (k == 4));
            check("ldi_imm_out", imm_out, 8'hA5);
            check("ldi_imm_ready_low", imm_ready, 0);
            if (k == 4) begin
                check("ldi_wr_sel", wr_sel, 3'd1);
                check("ldi_src_sel", src_sel, 2'b11);
            end
            tick;
        end
        #1;
        check("ldi_done_op_ready", op_ready, 1);
        check("ldi_done_busy", busy, 0);

        // Unsupported opcodes: one-clock pulse, stay idle
        for (int u = 0; u < 2; u++) begin
            op = unsup_ops[u];
            op_valid = 1'b1;
            tick;
            op_valid = 1'b0;
            #1;
            check("unsup_pulse", op_unsup, 1);
            check("unsup_busy", busy, 0);
            check("unsup_op_ready", op_ready, 1);
            check("unsup_rd_en", rd_en, 0);
            check("unsup_wr_en", wr_en, 0);
            tick;
            #1;
            check("unsup_pulse_end", op_unsup, 0);
        end

        // HALT, then an LD held pending until wake
        op = 8'h76;
        op_valid = 1'b1;
        tick;
        op = 8'h47;
        for (int h = 0; h < 3; h++) begin
            #1;
            check("halt_halted", halted, 1);
            check("halt_op_ready", op_ready, 0);
            check("halt_busy", busy, 1);
            tick;
        end
        wake = 1'b1;
        #1;
        check("wake_still_halted", halted, 1);
        tick;
        wake = 1'b0;
        #1;
        check("wake_halted_clear", halted, 0);
        ld_rr_run(8'h47, 3'd7, 3'd0);

        // Reset during the WR dwell of LD D,E
        op = 8'h53;
        op_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("mid_rd_en", rd_en, (c == 4));
            check("mid_wr_en", wr_en, 0);
            tick;
            if (c == 0) op_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", wr_en, 0);
        tick;
        #1;
        reset_vals("mid_rst");
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            tick;
            #1;
            check("post_rst_wr_en", wr_en, 0);
            check("post_rst_busy", busy, 0);
        end
        tick;
        ld_rr_run(8'h53, 3'd3, 3'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
- Multi-cycle controller that sequences the 8-bit register file for the first register-transfer opcodes: NOP, LD r,r', LD r,d8 and HALT.
- Accepts one opcode at a time from fetch via a valid/ready handshake.
- Drives the register file read/write enables, selects and the data-in source select, and takes immediates over a second handshake.
- Sits between fetch/decode and register_file_new. It replaces ad-hoc decode-driven enables with an explicit state machine.

Parameters:
- T_PER_M, 4, clocks per machine cycle. Each state dwells T_PER_M clocks; legal range is 1 to 8.
- SEL_W, 3, register select width (B=0, C=1, D=2, E=3, H=4, L=5, (HL)=6, A=7).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  opcode available
- op  in  8  opcode
- op_ready  out  1  sequencer accepts op this cycle
- imm_valid  in  1  immediate byte available
- imm_data  in  8  immediate byte, forwarded unchanged to imm_out
- imm_ready  out  1  immediate consumed this cycle
- imm_out  out  8  data presented on the src_sel=2'b11 input mux leg
- wake  in  1  exits HALT
- reg_rd_en  out  1  register file read enable
- reg_rd_sel  out  SEL_W  read select
- reg_wr_en  out  1  register file write enable
- reg_wr_sel  out  SEL_W  write select
- reg_src_sel  out  2  2'b00 = loopback of reg data_out, 2'b11 = imm_out
- busy  out  1  not in IDLE
- halted  out  1  in HALT
- op_unsupported  out  1  one-clock pulse when an opcode is treated as NOP

Behaviour:
- Reset (sync, rst=1 at posedge) forces state to IDLE and the T-counter to 0.
- Reset values: every output is 0 except op_ready, which is 1. rst takes priority over all events, including mid-operation and in HALT. Enables are low the first cycle after reset. A partially executed LD produces no write.
- States: IDLE, RD, WR, WAIT_IMM, IMM_WR, HALT.
- T-counter: counts 0..T_PER_M-1 in RD, WR and IMM_WR, and clears on every state change. reg_rd_en and reg_wr_en are asserted only when the counter equals T_PER_M-1, for exactly one clock per access.
- IDLE: op_ready=1. The opcode is captured when op_valid and op_ready are both high. Decode of the captured opcode:
  - 8'h00 (NOP): stay in IDLE, no enables. Latency is the accept clock only.
  - 01ddd sss with dd≠6 and sss≠6 (LD r,r'): go to RD, with src=sss and dst=ddd.
  - 8'h76 (HALT): go to HALT.
  - 00ddd110 with ddd≠6 (LD r,d8): go to WAIT_IMM.
  - Anything else, including any (HL) form: op_unsupported pulses on the accept clock and the state stays IDLE.
- RD: reg_rd_sel=src throughout. rd_en fires on the final T, then go to WR.
- WR: reg_wr_sel=dst and reg_src_sel=2'b00 throughout. wr_en fires on the final T, then go to IDLE.
  - Total LD r,r' length is 2*T_PER_M clocks after accept.
  - LD r,r with src=dst is legal and executes normally.
- WAIT_IMM: imm_ready=imm_valid, so the byte is taken in the same cycle valid is seen. imm_data is latched into imm_out and the state goes to IMM_WR. The sequencer waits indefinitely for imm_valid.
- IMM_WR: reg_wr_sel=dst and reg_src_sel=2'b11. imm_out is held stable. wr_en fires on the final T, then go to IDLE.
- HALT: halted=1. wake=1 returns to IDLE on the next clock. An op_valid seen while halted is not accepted.
- op_ready=0 and imm_ready=0 in every state other than IDLE and WAIT_IMM respectively. An early imm_valid is never consumed outside WAIT_IMM.
- An op_valid held while busy is not consumed. It is accepted on the first IDLE clock.
- Outputs are registered or pure functions of the state and counter. No combinational path from op to the enables.
- Select outputs hold their last value while idle. Only the enables are qualified.

Decomposition:
- Shared package gb_cpu_pkg holds:
  - register index constants (REG_B..REG_A, REG_HL_IND = 6)
  - src-select constants (SRC_LOOP = 2'b00, SRC_TB = 2'b11)
  - opcode constants (OP_NOP, OP_HALT)
  - the sequencer state enum
- Natural sub-module: mcycle_counter, a T-state counter with clear and last-T flag. It is reused later by the memory-bus sequencer.

Test Plan:
- Reset/NOP: rst=1 for 2 clocks, then op=8'h00 valid. Required: op_ready stays 1, no enables, busy=0, and a 4-clock gap is not needed.
- LD B,A (8'h47), T_PER_M=4: accept at cycle 0. Required: rd_en=1 with rd_sel=7 at cycle 4 only; wr_en=1 with wr_sel=0 and src_sel=00 at cycle 8 only; op_ready=1 again at cycle 9.
- LD C,d8 (8'h0E): imm_valid held low for 5 clocks, then imm_data=8'hA5. Required: imm_ready pulses once; wr_en with wr_sel=1, src_sel=11 and imm_out=8'hA5 on the 4th clock after capture.
- Unsupported 8'h7E and 8'h36: op_unsupported pulses 1 clock each, no enables, state stays IDLE.
- HALT 8'h76 followed by op_valid with 8'h47. Required: halted=1 and op_ready=0 until wake. After wake, IDLE on the next clock and 8'h47 is accepted.
- Reset mid-op: rst asserted during the WR dwell of LD D,E (8'h53). Required: no wr_en, all outputs at reset values, and the next op accepted normally.
